// File: rtl/fp_align_shifter.sv
// fp_align_shifter
//   Operand-alignment stage of the FP adder/subtractor. Orders two unpacked
//   operands by magnitude, shifts the smaller mantissa right by the exponent
//   difference, and derives the sticky bit by comparing the shift amount
//   against the trailing-zero count of the smaller mantissa. This avoids a
//   wide OR-reduce over the shifted-out bits.
//   Two registered stages with valid/ready on both sides. There is no skid
//   buffer, so in_ready is combinational from out_ready.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready     upstream handshake for one operand pair
//   exp_a_i, exp_b_i        biased exponents
//   mant_a_i, mant_b_i      W-bit mantissas (MSB = hidden bit, LSB = guard)
//   sign_a_i, sign_b_i      operand signs
//   out_valid / out_ready   downstream handshake for one aligned result
//   exp_o                   larger exponent
//   mant_large_o            larger-magnitude mantissa, unshifted
//   mant_small_o            smaller mantissa shifted right by the difference
//   sticky_o                OR of all bits shifted out of the small mantissa
//   sign_large_o/small_o    signs after ordering
//   swap_o                  1 when operand B had the larger magnitude

// Trailing-zero count of a W-bit mantissa (W = SizeMantissa + 2).
// An all-zero input reports SizeMantissa. The alignment stage ignores the
// count in that case, because a zero mantissa never produces a sticky bit.
module trailing_zero_counter #(
  parameter int SizeMantissa = 23
) (
  input  logic [SizeMantissa+1:0]              mant,
  output logic [$clog2(SizeMantissa+3)-1:0]    tz
);
  localparam int W   = SizeMantissa + 2;
  localparam int TzW = $clog2(SizeMantissa + 3);

  always_comb begin
    tz = TzW'(SizeMantissa);
    // Scan from the MSB down so that the lowest set bit wins.
    for (int i = W - 1; i >= 0; i--) begin
      if (mant[i]) tz = TzW'(i);
    end
  end
endmodule

module fp_align_shifter #(
  parameter int SizeMantissa = 23,
  parameter int SizeExponent = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SizeExponent-1:0]   exp_a_i,
  input  logic [SizeExponent-1:0]   exp_b_i,
  input  logic [SizeMantissa+1:0]   mant_a_i,
  input  logic [SizeMantissa+1:0]   mant_b_i,
  input  logic                      sign_a_i,
  input  logic                      sign_b_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SizeExponent-1:0]   exp_o,
  output logic [SizeMantissa+1:0]   mant_large_o,
  output logic [SizeMantissa+1:0]   mant_small_o,
  output logic                      sticky_o,
  output logic                      sign_large_o,
  output logic                      sign_small_o,
  output logic                      swap_o
);
  localparam int W   = SizeMantissa + 2;
  localparam int TzW = $clog2(SizeMantissa + 3);

  // Right shift that saturates to zero once the difference covers the whole
  // mantissa. The difference can reach 2**SizeExponent-1, far beyond W.
  function automatic logic [W-1:0] shift_sat(input logic [W-1:0]            m,
                                             input logic [SizeExponent-1:0] d);
    if (32'(d) >= W) return '0;
    return m >> d;
  endfunction

  // A nonzero bit is lost exactly when the shift amount exceeds the number
  // of trailing zeros. A saturated shift loses every bit.
  function automatic logic sticky_bit(input logic [W-1:0]            m,
                                      input logic [SizeExponent-1:0] d,
                                      input logic [TzW-1:0]          t);
    if (m == '0) return 1'b0;
    if (32'(d) >= W) return 1'b1;
    return 32'(d) > 32'(t);
  endfunction

  // Handshake. Each stage advances when it is empty or when its successor
  // advances.
  logic vld_p1, vld_p2;
  logic adv_p1, adv_p2;

  assign adv_p2   = !vld_p2 || out_ready;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign in_ready = adv_p1;

  // ---- stage 0: magnitude ordering (combinational on inputs) ----
  logic                    swap_c;
  logic [SizeExponent-1:0] exp_large_c, exp_small_c, diff_c;
  logic [W-1:0]            mant_large_c, mant_small_c;
  logic                    sign_large_c, sign_small_c;
  logic [TzW-1:0]          tz_c;

  always_comb begin
    // Ties keep A as the larger operand.
    swap_c       = (exp_b_i > exp_a_i) || ((exp_b_i == exp_a_i) && (mant_b_i > mant_a_i));
    exp_large_c  = swap_c ? exp_b_i  : exp_a_i;
    exp_small_c  = swap_c ? exp_a_i  : exp_b_i;
    mant_large_c = swap_c ? mant_b_i : mant_a_i;
    mant_small_c = swap_c ? mant_a_i : mant_b_i;
    sign_large_c = swap_c ? sign_b_i : sign_a_i;
    sign_small_c = swap_c ? sign_a_i : sign_b_i;
    diff_c       = exp_large_c - exp_small_c;
  end

  trailing_zero_counter #(.SizeMantissa(SizeMantissa)) u_tzc (
    .mant (mant_small_c),
    .tz   (tz_c)
  );

  // ---- stage 1: ordered fields, exponent difference, trailing zeros ----
  logic [SizeExponent-1:0] exp_p1, diff_p1;
  logic [W-1:0]            mant_large_p1, mant_small_p1;
  logic                    sign_large_p1, sign_small_p1, swap_p1;
  logic [TzW-1:0]          tz_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      exp_p1        <= '0;
      diff_p1       <= '0;
      mant_large_p1 <= '0;
      mant_small_p1 <= '0;
      sign_large_p1 <= 1'b0;
      sign_small_p1 <= 1'b0;
      swap_p1       <= 1'b0;
      tz_p1         <= '0;
    end else if (adv_p1) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        exp_p1        <= exp_large_c;
        diff_p1       <= diff_c;
        mant_large_p1 <= mant_large_c;
        mant_small_p1 <= mant_small_c;
        sign_large_p1 <= sign_large_c;
        sign_small_p1 <= sign_small_c;
        swap_p1       <= swap_c;
        tz_p1         <= tz_c;
      end
    end
  end

  // ---- stage 2: aligned small mantissa and sticky bit (outputs) ----
  logic [SizeExponent-1:0] exp_p2;
  logic [W-1:0]            mant_large_p2, mant_small_p2;
  logic                    sticky_p2, sign_large_p2, sign_small_p2, swap_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2        <= 1'b0;
      exp_p2        <= '0;
      mant_large_p2 <= '0;
      mant_small_p2 <= '0;
      sticky_p2     <= 1'b0;
      sign_large_p2 <= 1'b0;
      sign_small_p2 <= 1'b0;
      swap_p2       <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        exp_p2        <= exp_p1;
        mant_large_p2 <= mant_large_p1;
        mant_small_p2 <= shift_sat(mant_small_p1, diff_p1);
        sticky_p2     <= sticky_bit(mant_small_p1, diff_p1, tz_p1);
        sign_large_p2 <= sign_large_p1;
        sign_small_p2 <= sign_small_p1;
        swap_p2       <= swap_p1;
      end
    end
  end

  assign out_valid    = vld_p2;
  assign exp_o        = exp_p2;
  assign mant_large_o = mant_large_p2;
  assign mant_small_o = mant_small_p2;
  assign sticky_o     = sticky_p2;
  assign sign_large_o = sign_large_p2;
  assign sign_small_o = sign_small_p2;
  assign swap_o       = swap_p2;
endmodule

// File: tb/tb_fp_align_shifter.sv
// Scoreboard bench for fp_align_shifter. Directed operand pairs carry
// hand-computed results. Each accepted pair pushes its expected result, and
// a monitor pops and compares on every emitted result. The monitor also
// checks in_ready against the pipeline occupancy and output stability while
// stalled.
module tb_fp_align_shifter;
  localparam int SM = 23;
  localparam int SE = 8;
  localparam int W  = SM + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SE-1:0] exp_a_i = '0, exp_b_i = '0;
  logic [W-1:0]  mant_a_i = '0, mant_b_i = '0;
  logic          sign_a_i = 1'b0, sign_b_i = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SE-1:0] exp_o;
  logic [W-1:0]  mant_large_o, mant_small_o;
  logic          sticky_o, sign_large_o, sign_small_o, swap_o;

  fp_align_shifter #(.SizeMantissa(SM), .SizeExponent(SE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .exp_a_i      (exp_a_i),
    .exp_b_i      (exp_b_i),
    .mant_a_i     (mant_a_i),
    .mant_b_i     (mant_b_i),
    .sign_a_i     (sign_a_i),
    .sign_b_i     (sign_b_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .exp_o        (exp_o),
    .mant_large_o (mant_large_o),
    .mant_small_o (mant_small_o),
    .sticky_o     (sticky_o),
    .sign_large_o (sign_large_o),
    .sign_small_o (sign_small_o),
    .swap_o       (swap_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SE-1:0] ea, eb;
    logic [W-1:0]  ma, mb;
    logic          sa, sb;
    logic [SE-1:0] x_exp;
    logic [W-1:0]  x_ml, x_ms;
    logic          x_st, x_sl, x_ss, x_sw;
  } vec_t;

  // Packed result layout: exp, mant_large, mant_small, sticky, sign_l, sign_s, swap.
  typedef logic [SE+2*W+4-1:0] res_t;

  vec_t vecs [17];
  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   occ      = 0;
  int   cur_idx  = 0;

  function automatic res_t pack_exp(input vec_t v);
    return {v.x_exp, v.x_ml, v.x_ms, v.x_st, v.x_sl, v.x_ss, v.x_sw};
  endfunction

  function automatic res_t dut_res();
    return {exp_o, mant_large_o, mant_small_o, sticky_o, sign_large_o, sign_small_o, swap_o};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic [SE-1:0] ea, eb, input logic [W-1:0] ma, mb,
                              input logic sa, sb, input logic [SE-1:0] xe,
                              input logic [W-1:0] xl, xs, input logic st, sl, ss, sw);
    vec_t v;
    v.ea = ea; v.eb = eb; v.ma = ma; v.mb = mb; v.sa = sa; v.sb = sb;
    v.x_exp = xe; v.x_ml = xl; v.x_ms = xs; v.x_st = st; v.x_sl = sl; v.x_ss = ss; v.x_sw = sw;
    return v;
  endfunction

  initial begin
    //             ea   eb   ma          mb         sa sb  exp  mant_large  mant_small st sl ss sw
    vecs[0]  = mk(130, 128, 25'h1000000, 25'h1000001, 0, 1, 130, 25'h1000000, 25'h0400000, 1, 0, 1, 0);
    vecs[1]  = mk(100, 103, 25'h1000008, 25'h1800000, 1, 0, 103, 25'h1800000, 25'h0200001, 0, 0, 1, 1);
    vecs[2]  = mk(200, 150, 25'h1000000, 25'h1000000, 0, 0, 200, 25'h1000000, 25'h0000000, 1, 0, 0, 0);
    vecs[3]  = mk(200, 150, 25'h1000000, 25'h0000000, 1, 0, 200, 25'h1000000, 25'h0000000, 0, 1, 0, 0);
    vecs[4]  = mk(127, 127, 25'h1400000, 25'h1400000, 0, 1, 127, 25'h1400000, 25'h1400000, 0, 0, 1, 0);
    vecs[5]  = mk(127, 127, 25'h1400000, 25'h1400001, 0, 1, 127, 25'h1400001, 25'h1400000, 0, 1, 0, 1);
    vecs[6]  = mk(150, 126, 25'h1000000, 25'h1000001, 0, 0, 150, 25'h1000000, 25'h0000001, 1, 0, 0, 0);
    vecs[7]  = mk(151, 126, 25'h1000000, 25'h1000000, 0, 1, 151, 25'h1000000, 25'h0000000, 1, 0, 1, 0);
    vecs[8]  = mk( 10,   8, 25'h1000000, 25'h0000000, 1, 1,  10, 25'h1000000, 25'h0000000, 0, 1, 1, 0);
    vecs[9]  = mk(  5,   6, 25'h1234567, 25'h1000000, 1, 0,   6, 25'h1000000, 25'h091A2B3, 1, 0, 1, 1);
    vecs[10] = mk( 20,  16, 25'h1FFFFFF, 25'h1000010, 0, 1,  20, 25'h1FFFFFF, 25'h0100001, 0, 0, 1, 0);
    vecs[11] = mk(  0,   0, 25'h0000000, 25'h0000000, 1, 0,   0, 25'h0000000, 25'h0000000, 0, 1, 0, 0);
    vecs[12] = mk(255,   0, 25'h1800000, 25'h0000001, 0, 1, 255, 25'h1800000, 25'h0000000, 1, 0, 1, 0);
    vecs[13] = mk(  9,   9, 25'h0000010, 25'h1000000, 0, 1,   9, 25'h1000000, 25'h0000010, 0, 1, 0, 1);
    vecs[14] = mk( 50,  40, 25'h1100000, 25'h1000003, 1, 1,  50, 25'h1100000, 25'h0004000, 1, 1, 1, 0);
    vecs[15] = mk( 60,  61, 25'h1000000, 25'h1000000, 0, 0,  61, 25'h1000000, 25'h0800000, 0, 0, 0, 1);
    vecs[16] = vecs[0];
  end

  // Monitor and scoreboard. Runs on the falling edge, so every handshake
  // sampled here completes on the next rising edge.
  logic held_vld = 1'b0;
  res_t held_res;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        occ      = 0;
        held_vld = 1'b0;
      end else begin
        logic acc, emit;
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        chk("in_ready", 128'(in_ready), 128'((occ < 2) || out_ready));
        if (held_vld) chk("stall_stable", 128'(dut_res()), 128'(held_res));
        if (emit) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 128'(dut_res()), 128'(0));
            if (dut_res() == '0) begin n_fail++; $display("FAIL unexpected_output: out_valid=1 with empty scoreboard at %0t", $time); end
          end else begin
            chk("result", 128'(dut_res()), 128'(exp_q.pop_front()));
          end
          occ--;
        end
        held_vld = out_valid && !out_ready;
        held_res = dut_res();
        if (acc) begin
          exp_q.push_back(pack_exp(vecs[cur_idx]));
          occ++;
        end
      end
    end
  end

  task automatic send(input int idx);
    int n;
    in_valid = 1'b1;
    exp_a_i  = vecs[idx].ea;  exp_b_i  = vecs[idx].eb;
    mant_a_i = vecs[idx].ma;  mant_b_i = vecs[idx].mb;
    sign_a_i = vecs[idx].sa;  sign_b_i = vecs[idx].sb;
    cur_idx  = idx;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=0 for 50 cycles, vector %0d", idx);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    // Check the reset state while rst_n is held low.
    #3;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_outputs", 128'(dut_res()), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    #20 rst_n = 1'b1;
    idle(2);
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));

    // Basic shift with a two-cycle latency check.
    send(0);
    @(posedge clk); #1;
    chk("latency_valid", 128'(out_valid), 128'(1));
    idle(2);

    // Directed alignment cases, streamed back to back.
    for (int i = 1; i <= 8; i++) send(i);
    idle(4);

    // Backpressure. out_ready drops for 3 cycles in the middle of the stream.
    fork
      begin
        for (int i = 9; i <= 13; i++) send(i);
      end
      begin
        idle(2);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
      end
    join
    idle(4);

    // Reset with two pairs in flight.
    send(14);
    send(15);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_outputs", 128'(dut_res()), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    idle(2);
    #2 rst_n = 1'b1;
    idle(5);
    chk("no_stale_output", 128'(out_valid), 128'(0));

    // Operation after reset recovery.
    send(16);
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) idle(1);
    idle(1);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
